sysbus_mem_responder: RTL and testbench
=======================================

// Module: sysbus_mem_responder
// PURPOSE
// - Memory-side responder for the Sysbus read/write protocol driven by the core fetch/load path.
// - Accepts one 64-byte line request, acks it, then streams 8x64-bit beats (read) or absorbs 8 beats (write).
// - Backed by an internal word array; used as the line-fill target in unit benches and in small integrated sims.
// PARAMETERS
// - MEM_WORDS   2048  depth of backing store in 64-bit words; multiple of 8; line index wraps modulo MEM_WORDS/8
// - RD_LATENCY  4     idle cycles between reqack and the first read beat (>=0)
// - TAG_W       13    tag width; reqtag[TAG_W-1] = 1 READ, 0 WRITE; remaining bits opaque, echoed
// PORTS
// - clk      in   1      clock, all logic on posedge
// - reset    in   1      synchronous, active-high
// - reqcyc   in   1      request/write-data valid
// - req      in   64     request address (in REQ cycle) or write data (in WDATA state)
// - reqtag   in   TAG_W  request tag, sampled with address
// - reqack   out  1      one-cycle request accept pulse
// - respcyc  out  1      read beat valid
// - resp     out  64     read beat data
// - resptag  out  TAG_W  captured reqtag, valid while respcyc
// - respack  in   1      initiator accepts current beat
// BEHAVIOUR
// - Reset: reqack=0, respcyc=0, resp=0, resptag=0, state=IDLE, beat=0, lat_cnt=0; array contents NOT cleared.
// - Reset mid-operation aborts the transaction; respcyc is 0 the cycle after reset; partial write beats already stored stay stored.
// - States: IDLE -> ACK -> (READ: WAIT -> RESP | WRITE: WDATA) -> IDLE.
// - IDLE: reqcyc=1 sampled -> latch req[63:6] as line, reqtag as tag, go ACK. reqcyc ignored in every other state.
// - ACK: reqack=1 for exactly one cycle (reqcyc->reqack latency = 1 cycle). Next: READ -> WAIT with lat_cnt=RD_LATENCY; WRITE -> WDATA, beat=0.
// - Initiator holds reqcyc until reqack; the cycle reqack is high does not start a new request.
// - WAIT: decrement lat_cnt; at 0 go RESP (RD_LATENCY=0 -> RESP directly after ACK).
// - RESP: respcyc=1, resp=mem[{line_idx,beat}], resptag=tag. Beat advances only on respcyc&&respack;
//   with respack=0, resp/resptag/respcyc hold stable. After the 8th accepted beat: respcyc=0 next cycle, IDLE.
// - WDATA: each cycle with reqcyc=1 writes req into mem[{line_idx,beat}], beat++; after beat 7 -> IDLE. reqcyc=0 cycles stall.
// - line_idx = line mod (MEM_WORDS/8); beat is a 3-bit counter, wraps 7->0 only at transaction end.
// - Minimum read turnaround: next request accepted in IDLE the cycle after the last beat.
// - req[5:0] ignored for addressing unless the optional feature below is compiled in.
// CONFIGURATION
// - SYSBUS_CRITICAL_WORD_FIRST_EN defined: read beats start at word req[5:3] and wrap modulo 8
//   (e.g. req[5:3]=5 -> order 5,6,7,0,1,2,3,4); write beats unaffected (always 0..7).
// - Undefined: read beats always in order 0..7 from the line base; req[5:3] ignored.
// TESTING
// - Reset check: hold reset 3 cycles with reqcyc=1 -> reqack=0, respcyc=0, resp=0 throughout; first reqack 1 cycle after reset drops.
// - Read, RD_LATENCY=4, mem line 2 = 64'h10..64'h17, req=64'h80 READ, respack=1 -> reqack at T+1, respcyc T+6..T+13, resp 10..17, resptag=reqtag.
// - Backpressure: same read, respack=0 on beats 3 and 5 for 2 cycles each -> beat data held stable, 8 beats total, respcyc high 12 cycles.
// - Write then read: WRITE req=64'h1C0, data AA00..AA07 with one reqcyc=0 gap -> read of 64'h1C0 returns AA00..AA07.
// - Wrap: MEM_WORDS=2048, READ req=64'h4080 (line 258) -> returns contents of line 2; reqcyc during RESP ignored (no second reqack).
// - Feature on: READ req=64'h28 -> resp order words 5,6,7,0,1,2,3,4; reset asserted during beat 3 -> respcyc=0 next cycle, IDLE.

Source files
------------

// File: rtl/sysbus_if.sv
// sysbus_if: Sysbus request/response bundle between an initiator (master) and a memory responder (slave)
//   reqcyc  : request / write-data valid          (master -> slave)
//   req     : address in the request cycle, write data afterwards
//   reqtag  : request tag, MSB 1 = READ, 0 = WRITE
//   reqack  : one-cycle request accept pulse       (slave -> master)
//   respcyc : read beat valid
//   resp    : read beat data
//   resptag : tag of the transaction owning the beat
//   respack : initiator accepts the current beat   (master -> slave)
interface sysbus_if #(
  parameter int TAG_W = 13
) ();
  logic reqcyc;
  logic [63:0] req;
  logic [TAG_W-1:0] reqtag;
  logic reqack;
  logic respcyc;
  logic [63:0] resp;
  logic [TAG_W-1:0] resptag;
  logic respack;
  modport master (
    output reqcyc, req, reqtag, respack,
    input reqack, respcyc, resp, resptag
  );
  modport slave (
    input reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: memory-side Sysbus responder serving 64-byte lines as 8x64-bit beats
//   clk   : clock, everything on posedge
//   reset : synchronous active-high reset (backing store is not cleared)
//   bus   : sysbus_if.slave (reqcyc/req/reqtag/respack in, reqack/respcyc/resp/resptag out)
//   Optional macro SYSBUS_CRITICAL_WORD_FIRST_EN: read beats start at word req[5:3] and wrap.
module sysbus_mem_responder #(
  parameter int MEM_WORDS = 2048,
  parameter int RD_LATENCY = 4,
  parameter int TAG_W = 13
) (
  input logic clk,
  input logic reset,
  sysbus_if.slave bus
);
  localparam int LINES = MEM_WORDS / 8;
  localparam int LW = LINES > 1 ? $clog2(LINES) : 1;
  localparam int LCW = RD_LATENCY > 1 ? $clog2(RD_LATENCY + 1) : 1;
  typedef enum logic [2:0] {IDLE, ACK, WAIT, RESP, WDATA} state_t;
  state_t state, stateNext;
  logic [63:0] mem [MEM_WORDS];
  logic [LW-1:0] lineIdx;
  logic [TAG_W-1:0] tag;
  logic [2:0] beat, beatNext, start;
  logic [LCW-1:0] latCnt, latCntNext;
  logic memWe;
  logic accept;
  assign accept = state == IDLE && bus.reqcyc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      latCnt <= '0;
      lineIdx <= '0;
      tag <= '0;
    end else begin
      state <= stateNext;
      beat <= beatNext;
      latCnt <= latCntNext;
      if (accept) begin
        lineIdx <= LW'(bus.req[63:6] % 58'(LINES));
        tag <= bus.reqtag;
      end
    end
  end
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
  always_ff @(posedge clk) begin
    if (reset) start <= '0;
    else if (accept) start <= bus.req[5:3];
  end
`else
  assign start = 3'd0;
`endif
  // latCnt counts down the idle WAIT cycles; RESP is entered as it reaches zero
  always_comb begin
    stateNext = state;
    beatNext = beat;
    latCntNext = latCnt;
    memWe = 1'b0;
    case (state)
      IDLE: stateNext = bus.reqcyc ? ACK : IDLE;
      ACK: begin
        beatNext = '0;
        latCntNext = LCW'(RD_LATENCY);
        stateNext = !tag[TAG_W-1] ? WDATA : (RD_LATENCY == 0 ? RESP : WAIT);
      end
      WAIT: begin
        latCntNext = latCnt - 1'b1;
        stateNext = latCnt == LCW'(1) ? RESP : WAIT;
      end
      RESP: begin
        beatNext = bus.respack ? beat + 1'b1 : beat;
        stateNext = bus.respack && beat == 3'd7 ? IDLE : RESP;
      end
      WDATA: begin
        memWe = bus.reqcyc && !reset;
        beatNext = bus.reqcyc ? beat + 1'b1 : beat;
        stateNext = bus.reqcyc && beat == 3'd7 ? IDLE : WDATA;
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (memWe) mem[{lineIdx, beat}] <= bus.req;
  end
  assign bus.reqack = state == ACK;
  assign bus.respcyc = state == RESP;
  assign bus.resp = bus.respcyc ? mem[{lineIdx, beat + start}] : '0;
  assign bus.resptag = bus.respcyc ? tag : '0;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: randomized self-checking bench for sysbus_mem_responder against a line-array model
module tb_sysbus_mem_responder;
  localparam int MEM_WORDS = 2048;
  localparam int RD_LATENCY = 4;
  localparam int TAG_W = 13;
  localparam int LINES = MEM_WORDS / 8;
  typedef logic [63:0] line_t [8];
  typedef int stall_t [8];
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failures = 0;
  logic [63:0] model [MEM_WORDS];
  int written[$];
  line_t rGot, d, e;
  stall_t noStall = '{default: 0};
  stall_t st;
  int rAck, rFirst, rHigh, rHeld, rTagBad, rExtra, wAck;
  bit rDone, rTo, wTo;
  logic [TAG_W-1:0] tg;
  sysbus_if #(.TAG_W(TAG_W)) bus ();
  sysbus_mem_responder #(.MEM_WORDS(MEM_WORDS), .RD_LATENCY(RD_LATENCY), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  function automatic int lineOf(input logic [63:0] a);
    return int'((a >> 6) % LINES);
  endfunction
  function automatic line_t expLine(input logic [63:0] a);
    line_t r;
    int s;
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
    s = int'(a[5:3]);
`else
    s = 0;
`endif
    for (int i = 0; i < 8; i++) r[i] = model[lineOf(a) * 8 + (s + i) % 8];
    return r;
  endfunction
  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction
  task automatic busWrite(input logic [63:0] addr, input line_t dat, input int gap, input int abortAfter);
    int cyc = 0;
    wTo = 0;
    wAck = -1;
    bus.reqcyc = 1'b1;
    bus.req = addr;
    bus.reqtag = {1'b0, (TAG_W-1)'($urandom)};
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.reqack && cyc < 20);
    bus.reqcyc = 1'b0;
    if (!bus.reqack) begin
      wTo = 1;
      return;
    end
    wAck = cyc;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == abortAfter) begin
        reset = 1'b1;
        bus.reqcyc = 1'b0;
        return;
      end
      if (i == gap) begin
        bus.reqcyc = 1'b0;
        bus.req = rnd64();
        @(negedge clk);
      end
      bus.reqcyc = 1'b1;
      bus.req = dat[i];
      @(negedge clk);
      model[lineOf(addr) * 8 + i] = dat[i];
    end
    bus.reqcyc = 1'b0;
    written.push_back(lineOf(addr));
  endtask
  task automatic busRead(input logic [63:0] addr, input logic [TAG_W-1:0] t, input stall_t stall,
                         input bit holdReq, input int abortAfter);
    int cyc = 0;
    int n = 0;
    int w = 0;
    bit prevHeld = 0;
    logic [63:0] prevData = '0;
    rGot = '{default: '0};
    rAck = -1;
    rFirst = -1;
    rHigh = 0;
    rHeld = 0;
    rTagBad = 0;
    rExtra = 0;
    rDone = 0;
    rTo = 0;
    bus.reqcyc = 1'b1;
    bus.req = addr;
    bus.reqtag = t;
    bus.respack = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.reqack && cyc < 20);
    if (!bus.reqack) begin
      bus.reqcyc = 1'b0;
      rTo = 1;
      return;
    end
    rAck = cyc;
    bus.reqcyc = holdReq;
    while (n < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.reqack) rExtra++;
      if (bus.respcyc) begin
        if (rFirst < 0) rFirst = cyc;
        rHigh++;
        if (bus.resptag !== t) rTagBad++;
        if (prevHeld && bus.resp !== prevData) rHeld++;
        if (n == abortAfter) begin
          reset = 1'b1;
          bus.respack = 1'b0;
          bus.reqcyc = 1'b0;
          return;
        end
        if (w < stall[n]) begin
          w++;
          bus.respack = 1'b0;
          prevHeld = 1;
          prevData = bus.resp;
        end else begin
          bus.respack = 1'b1;
          rGot[n] = bus.resp;
          n++;
          w = 0;
          prevHeld = 0;
        end
      end else bus.respack = 1'b0;
    end
    bus.reqcyc = 1'b0;
    if (n < 8) begin
      rTo = 1;
      bus.respack = 1'b0;
      return;
    end
    @(negedge clk);
    bus.respack = 1'b0;
    rDone = !bus.respcyc && !bus.reqack;
  endtask
  task automatic test_reset();
    bus.reqcyc = 1'b1;
    bus.req = 64'h0;
    bus.reqtag = {1'b0, (TAG_W-1)'($urandom)};
    bus.respack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests += 3;
      if (bus.reqack !== 1'b0) begin failures++; $display("FAIL reset_reqack: got %b want 0", bus.reqack); end
      if (bus.respcyc !== 1'b0) begin failures++; $display("FAIL reset_respcyc: got %b want 0", bus.respcyc); end
      if (bus.resp !== 64'h0) begin failures++; $display("FAIL reset_resp: got %h want 0", bus.resp); end
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = rnd64();
    busWrite(64'h0, d, -1, -1);
    tests++;
    if (wTo || wAck !== 1) begin failures++; $display("FAIL reset_first_ack: got latency %0d (timeout %0b) want 1", wAck, wTo); end
  endtask
  task automatic test_read_basic();
    for (int i = 0; i < 8; i++) d[i] = 64'h10 + 64'(i);
    busWrite(64'h80, d, -1, -1);
    tg = {1'b1, (TAG_W-1)'($urandom)};
    busRead(64'h80, tg, noStall, 0, -1);
    e = expLine(64'h80);
    tests += 6;
    if (rTo) begin failures++; $display("FAIL read_timeout: got timeout want completion"); end
    if (rAck !== 1) begin failures++; $display("FAIL read_ack_latency: got %0d want 1", rAck); end
    if (rFirst !== 2 + RD_LATENCY) begin failures++; $display("FAIL read_first_beat: got cycle %0d want %0d", rFirst, 2 + RD_LATENCY); end
    if (rHigh !== 8) begin failures++; $display("FAIL read_respcyc_cycles: got %0d want 8", rHigh); end
    if (rTagBad !== 0) begin failures++; $display("FAIL read_resptag: got %0d bad beats want 0", rTagBad); end
    if (!rDone) begin failures++; $display("FAIL read_end: got respcyc/reqack high after last beat want low"); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rGot[i] !== e[i]) begin failures++; $display("FAIL read_beat%0d: got %h want %h", i, rGot[i], e[i]); end
    end
  endtask
  task automatic test_backpressure();
    st = noStall;
    st[3] = 2;
    st[5] = 2;
    busRead(64'h80, {1'b1, (TAG_W-1)'($urandom)}, st, 0, -1);
    e = expLine(64'h80);
    tests += 3;
    if (rTo || rHigh !== 12) begin failures++; $display("FAIL bp_respcyc_cycles: got %0d (timeout %0b) want 12", rHigh, rTo); end
    if (rHeld !== 0) begin failures++; $display("FAIL bp_hold_stable: got %0d changes want 0", rHeld); end
    if (!rDone) begin failures++; $display("FAIL bp_end: got respcyc high after 8 beats want low"); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rGot[i] !== e[i]) begin failures++; $display("FAIL bp_beat%0d: got %h want %h", i, rGot[i], e[i]); end
    end
  endtask
  task automatic test_write_read();
    for (int i = 0; i < 8; i++) d[i] = 64'hAA00 + 64'(i);
    busWrite(64'h1C0, d, 3, -1);
    tests++;
    if (wTo) begin failures++; $display("FAIL wr_timeout: got timeout want reqack"); end
    busRead(64'h1C0, {1'b1, (TAG_W-1)'($urandom)}, noStall, 0, -1);
    e = expLine(64'h1C0);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rGot[i] !== e[i]) begin failures++; $display("FAIL wr_rd_beat%0d: got %h want %h", i, rGot[i], e[i]); end
    end
  endtask
  task automatic test_wrap();
    busRead(64'h4080, {1'b1, (TAG_W-1)'($urandom)}, noStall, 1, -1);
    e = expLine(64'h4080);
    tests += 2;
    if (rTo || rExtra !== 0) begin failures++; $display("FAIL wrap_extra_ack: got %0d extra acks (timeout %0b) want 0", rExtra, rTo); end
    if (!rDone) begin failures++; $display("FAIL wrap_end: got respcyc/reqack high after last beat want low"); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rGot[i] !== e[i]) begin failures++; $display("FAIL wrap_beat%0d: got %h want %h", i, rGot[i], e[i]); end
    end
  endtask
  task automatic test_critical_word();
    busRead(64'h28, {1'b1, (TAG_W-1)'($urandom)}, noStall, 0, -1);
    e = expLine(64'h28);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rGot[i] !== e[i]) begin failures++; $display("FAIL cwf_beat%0d: got %h want %h", i, rGot[i], e[i]); end
    end
  endtask
  task automatic test_back_to_back();
    busRead(64'h1C0, {1'b1, (TAG_W-1)'($urandom)}, noStall, 0, -1);
    busRead(64'h88, {1'b1, (TAG_W-1)'($urandom)}, noStall, 0, -1);
    e = expLine(64'h88);
    tests++;
    if (rTo || rAck !== 1) begin failures++; $display("FAIL b2b_ack_latency: got %0d (timeout %0b) want 1", rAck, rTo); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rGot[i] !== e[i]) begin failures++; $display("FAIL b2b_beat%0d: got %h want %h", i, rGot[i], e[i]); end
    end
  endtask
  task automatic test_reset_abort();
    busRead(64'h28, {1'b1, (TAG_W-1)'($urandom)}, noStall, 0, 3);
    tests++;
    if (rTo) begin failures++; $display("FAIL abort_reach_beat3: got timeout want beat 3"); end
    @(negedge clk);
    tests += 2;
    if (bus.respcyc !== 1'b0) begin failures++; $display("FAIL abort_respcyc: got %b want 0", bus.respcyc); end
    if (bus.resp !== 64'h0) begin failures++; $display("FAIL abort_resp: got %h want 0", bus.resp); end
    reset = 1'b0;
    busRead(64'h28, {1'b1, (TAG_W-1)'($urandom)}, noStall, 0, -1);
    e = expLine(64'h28);
    tests++;
    if (rTo || rAck !== 1) begin failures++; $display("FAIL abort_restart: got ack latency %0d (timeout %0b) want 1", rAck, rTo); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rGot[i] !== e[i]) begin failures++; $display("FAIL abort_rd_beat%0d: got %h want %h", i, rGot[i], e[i]); end
    end
    for (int i = 0; i < 8; i++) d[i] = rnd64();
    busWrite(64'h240, d, -1, -1);
    for (int i = 0; i < 8; i++) d[i] = rnd64();
    busWrite(64'h240, d, -1, 3);
    @(negedge clk);
    tests++;
    if (bus.respcyc !== 1'b0) begin failures++; $display("FAIL abort_wr_respcyc: got %b want 0", bus.respcyc); end
    reset = 1'b0;
    busRead(64'h240, {1'b1, (TAG_W-1)'($urandom)}, noStall, 0, -1);
    e = expLine(64'h240);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rGot[i] !== e[i]) begin failures++; $display("FAIL abort_wr_beat%0d: got %h want %h", i, rGot[i], e[i]); end
    end
  endtask
  task automatic test_random();
    logic [63:0] a;
    int ln, bad;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 8; i++) d[i] = rnd64();
        busWrite(rnd64(), d, $urandom_range(0, 8), -1);
        tests++;
        if (wTo || wAck !== 1) begin failures++; $display("FAIL rnd%0d_wr_ack: got %0d (timeout %0b) want 1", k, wAck, wTo); end
      end else begin
        ln = written[$urandom_range(0, written.size() - 1)];
        a = ((64'($urandom_range(0, 1 << 20)) * LINES + 64'(ln)) << 6) | 64'($urandom_range(0, 63));
        for (int i = 0; i < 8; i++) st[i] = $urandom_range(0, 2);
        tg = {1'b1, (TAG_W-1)'($urandom)};
        busRead(a, tg, st, 1'($urandom_range(0, 1)), -1);
        e = expLine(a);
        bad = 0;
        for (int i = 0; i < 8; i++) if (rGot[i] !== e[i]) bad++;
        tests += 3;
        if (rTo || bad !== 0) begin failures++; $display("FAIL rnd%0d_rd_data: addr %h got %0d bad beats (timeout %0b) want 0", k, a, bad, rTo); end
        if (rHeld !== 0 || rTagBad !== 0) begin failures++; $display("FAIL rnd%0d_rd_hold_tag: got %0d/%0d want 0/0", k, rHeld, rTagBad); end
        if (!rDone || rExtra !== 0) begin failures++; $display("FAIL rnd%0d_rd_end: got done %0b extra %0d want 1/0", k, rDone, rExtra); end
      end
    end
  endtask
  initial begin
    bus.reqcyc = 1'b0;
    bus.req = '0;
    bus.reqtag = '0;
    bus.respack = 1'b0;
    test_reset();
    test_read_basic();
    test_backpressure();
    test_write_read();
    test_wrap();
    test_critical_word();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
